mem_access_stage: RTL and testbench

- RISC-V MEM pipeline stage, between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Performs load and store accesses to the data memory over a req/ready bus.
- Generates byte enables, aligns and extends load data, detects misaligned or illegal accesses, and stalls the pipeline until each access completes.
- Its outputs feed the MEM/WB register's read-data, ALU-result, rd, Mem_Read, Mem_to_Reg and Reg_Write inputs.

---
 rtl/mem_stage_pkg.sv | 38 +++
 rtl/mem_load_align.sv | 37 +++
 rtl/mem_access_stage.sv | 173 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared constants for the MEM pipeline stage: funct3 access encodings,
// FSM state constants and byte-enable patterns.
package mem_stage_pkg;

   // FSM state encoding.
   localparam int unsigned STATE_W = 2;
   localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
   localparam logic [STATE_W-1:0] ST_REQ  = 2'd1;
   localparam logic [STATE_W-1:0] ST_RESP = 2'd2;

   // funct3 access size / sign encodings.
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // Byte-enable patterns.
   localparam logic [3:0] BE_NONE    = 4'b0000;
   localparam logic [3:0] BE_BYTE0   = 4'b0001;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;
   localparam logic [3:0] BE_WORD    = 4'b1111;

   // Byte enables for an access of size funct3[1:0] at byte offset addr.
   function automatic logic [3:0] byte_enable(input logic [2:0] funct3,
                                              input logic [1:0] addr);
      logic [3:0] be;
      case (funct3[1:0])
         2'b00:   be = BE_BYTE0 << addr;
         2'b01:   be = addr[1] ? BE_HALF_HI : BE_HALF_LO;
         2'b10:   be = BE_WORD;
         default: be = BE_NONE;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: selects the addressed byte/half/word lane from the
// memory read word and sign- or zero-extends it to 32 bits.
module mem_load_align
   import mem_stage_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   // Lane selection followed by extension according to funct3.
   always_comb begin
      byte_lane = '0;
      half_lane = '0;
      result    = '0;
      case (addr)
         2'd0:    byte_lane = rdata[7:0];
         2'd1:    byte_lane = rdata[15:8];
         2'd2:    byte_lane = rdata[23:16];
         default: byte_lane = rdata[31:24];
      endcase
      half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
      case (funct3)
         F3_LB:   result = {{24{byte_lane[7]}}, byte_lane};
         F3_LBU:  result = {24'd0, byte_lane};
         F3_LH:   result = {{16{half_lane[15]}}, half_lane};
         F3_LHU:  result = {16'd0, half_lane};
         F3_LW:   result = rdata;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// RISC-V MEM pipeline stage: issues loads/stores on a req/ready data bus,
// generates byte enables and lane-replicated store data, aligns load data,
// flags misaligned/illegal accesses and stalls the pipeline until done.
// Optional feature: define MEM_TIMEOUT_EN to abort a REQ that sees no
// dmem_ready within TIMEOUT_CYCLES cycles.
module mem_access_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] RESET_DATA     = 32'h0000_0000
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_i,
   input  logic [31:0] alu_result_i,
   input  logic [31:0] store_data_i,
   input  logic [4:0]  rd_i,
   input  logic [2:0]  funct3_i,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic        mem_to_reg_i,
   input  logic        reg_write_i,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] read_data_o,
   output logic [31:0] alu_result_o,
   output logic [4:0]  rd_o,
   output logic        mem_read_o,
   output logic        mem_to_reg_o,
   output logic        reg_write_o,
   output logic        stall_o,
   output logic        access_err_o
);

   logic [STATE_W-1:0] state_q, state_d;
   logic [31:0]        cap_q;
   logic               err_q;
   logic               err_set;
   logic               mem_op;
   logic               f3_illegal;
   logic               misaligned;
   logic               access_bad;
   logic [3:0]         be_calc;
   logic [31:0]        load_aligned;
   logic               timeout_hit;

   assign mem_op     = valid_i & (mem_read_i | mem_write_i);
   // 011, 11x are never legal; unsigned variants only exist for loads.
   assign f3_illegal = (funct3_i == 3'b011) | (funct3_i[2:1] == 2'b11)
                     | (mem_write_i & funct3_i[2]);
   assign be_calc    = byte_enable(funct3_i, alu_result_i[1:0]);
   assign access_bad = f3_illegal | misaligned;

   // Misalignment check for half and word accesses.
   always_comb begin
      misaligned = 1'b0;
      case (funct3_i[1:0])
         2'b01:   misaligned = alu_result_i[0];
         2'b10:   misaligned = (alu_result_i[1:0] != 2'b00);
         default: misaligned = 1'b0;
      endcase
   end

   // Store data replicated across all lanes of the access size.
   always_comb begin
      dmem_wdata = store_data_i;
      case (funct3_i[1:0])
         2'b00:   dmem_wdata = {4{store_data_i[7:0]}};
         2'b01:   dmem_wdata = {2{store_data_i[15:0]}};
         default: dmem_wdata = store_data_i;
      endcase
   end

   mem_load_align u_load_align (
      .rdata  (dmem_rdata),
      .addr   (alu_result_i[1:0]),
      .funct3 (funct3_i),
      .result (load_aligned)
   );

`ifdef MEM_TIMEOUT_EN
   localparam int unsigned CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 16) ? 16 : CNT_RAW);

   logic [CNT_W-1:0] tmo_cnt_q;

   // Abort on the REQ cycle that would be the TIMEOUT_CYCLES-th without ready.
   assign timeout_hit = (state_q == ST_REQ) & ~dmem_ready
                      & (({{(32-CNT_W){1'b0}}, tmo_cnt_q} + 32'd1) >= TIMEOUT_CYCLES);

   // REQ cycle counter; cleared whenever the FSM is not staying in REQ.
   always_ff @(posedge clk) begin
      if (!reset) begin
         tmo_cnt_q <= '0;
      end else if ((state_q == ST_REQ) && (state_d == ST_REQ)) begin
         tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end else begin
         tmo_cnt_q <= '0;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // Next-state and error decision.
   always_comb begin
      state_d = state_q;
      err_set = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (mem_op) begin
               state_d = ST_RESP;
               err_set = access_bad;
               if (!access_bad) state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (dmem_ready) begin
               state_d = ST_RESP;
            end else if (timeout_hit) begin
               state_d = ST_RESP;
               err_set = 1'b1;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State, bus strobes, error flag and load capture registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         cap_q    <= RESET_DATA;
         err_q    <= 1'b0;
         dmem_req <= 1'b0;
         dmem_we  <= 1'b0;
         dmem_be  <= BE_NONE;
      end else begin
         state_q <= state_d;
         err_q   <= err_set;
         if ((state_q == ST_IDLE) && (state_d == ST_REQ)) begin
            dmem_req <= 1'b1;
            dmem_we  <= mem_write_i;
            dmem_be  <= be_calc;
         end else if ((state_q == ST_REQ) && (state_d != ST_REQ)) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            dmem_be  <= BE_NONE;
         end
         if ((state_q == ST_REQ) && dmem_ready) begin
            cap_q <= mem_write_i ? 32'd0 : load_aligned;
         end
      end
   end

   assign dmem_addr    = {alu_result_i[31:2], 2'b00};
   assign stall_o      = ((state_q == ST_IDLE) & mem_op) | (state_q == ST_REQ);
   assign read_data_o  = ((state_q == ST_RESP) & ~err_q) ? cap_q : 32'd0;
   assign access_err_o = err_q;
   assign reg_write_o  = reg_write_i & ~err_q;
   assign alu_result_o = alu_result_i;
   assign rd_o         = rd_i;
   assign mem_read_o   = mem_read_i;
   assign mem_to_reg_o = mem_to_reg_i;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: a driver issues directed and random
// ops and pushes model expectations; a monitor pops them when the stage
// releases the pipeline and checks results, bus fields and stall length.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_i;
   logic [31:0] alu_result_i;
   logic [31:0] store_data_i;
   logic [4:0]  rd_i;
   logic [2:0]  funct3_i;
   logic        mem_read_i, mem_write_i, mem_to_reg_i, reg_write_i;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;
   logic [31:0] read_data_o, alu_result_o;
   logic [4:0]  rd_o;
   logic        mem_read_o, mem_to_reg_o, reg_write_o, stall_o, access_err_o;

   always #5 clk = ~clk;

   mem_access_stage #(.TIMEOUT_CYCLES(255), .RESET_DATA(32'h0)) dut (
      .clk(clk), .reset(reset), .valid_i(valid_i), .alu_result_i(alu_result_i),
      .store_data_i(store_data_i), .rd_i(rd_i), .funct3_i(funct3_i),
      .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
      .mem_to_reg_i(mem_to_reg_i), .reg_write_i(reg_write_i),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
      .dmem_rdata(dmem_rdata), .read_data_o(read_data_o),
      .alu_result_o(alu_result_o), .rd_o(rd_o), .mem_read_o(mem_read_o),
      .mem_to_reg_o(mem_to_reg_o), .reg_write_o(reg_write_o),
      .stall_o(stall_o), .access_err_o(access_err_o)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        regw;
      logic        err;
      logic        req;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wdata;
      logic [31:0] addr;
      int          stalls;
      logic [31:0] alu;
      logic [4:0]  rd;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad   = 0;
   bit          mon_en = 1'b0;
   int          cur_delay = 0;
   logic [31:0] cur_rdata = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Memory responder: ready after cur_delay REQ cycles; random noise on
   // ready/rdata whenever no request is pending.
   initial begin
      int req_cnt = 0;
      dmem_ready = 1'b0;
      dmem_rdata = '0;
      forever begin
         @(negedge clk);
         if (dmem_req === 1'b1) begin
            dmem_ready = (req_cnt == cur_delay);
            dmem_rdata = (req_cnt == cur_delay) ? cur_rdata : $urandom;
            req_cnt++;
         end else begin
            req_cnt    = 0;
            dmem_ready = 1'($urandom_range(0, 1));
            dmem_rdata = $urandom;
         end
      end
   end

   // Monitor: checks bus fields when a request appears and pops the
   // expected result when the stage releases a valid instruction.
   initial begin
      int   stalls = 0;
      bit   bus_seen = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            stalls   = 0;
            bus_seen = 1'b0;
         end else begin
            if (dmem_req === 1'b1 && !bus_seen) begin
               bus_seen = 1'b1;
               if (sb.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_req: got req with empty scoreboard");
               end else if (sb[0].req) begin
                  chk("dmem_be", dmem_be, sb[0].be);
                  chk("dmem_we", dmem_we, sb[0].we);
                  chk("dmem_wdata", dmem_wdata, sb[0].wdata);
                  chk("dmem_addr", dmem_addr, sb[0].addr);
               end
            end
            if (stall_o === 1'b1) begin
               stalls++;
            end else if (valid_i === 1'b1) begin
               if (sb.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_result: got completion with empty scoreboard");
               end else begin
                  e = sb.pop_front();
                  chk("read_data", read_data_o, e.rdata);
                  chk("reg_write", reg_write_o, e.regw);
                  chk("access_err", access_err_o, e.err);
                  chk("bus_req_seen", bus_seen, e.req);
                  chk("stall_cycles", stalls, e.stalls);
                  chk("alu_pass", alu_result_o, e.alu);
                  chk("rd_pass", rd_o, e.rd);
               end
               stalls   = 0;
               bus_seen = 1'b0;
            end
         end
      end
   end

   // Issue one op, push its expected outcome, and hold it until released.
   task automatic issue(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [31:0] rdata, input int delay,
                        input logic regw, input logic [4:0] rdn);
      exp_t        e;
      logic        is_mem, illegal, misal, err;
      logic [1:0]  size, lane;
      logic        uns;
      logic [31:0] v;
      int          n;
      is_mem  = rd_en | wr_en;
      size    = f3[1:0];
      uns     = f3[2];
      lane    = addr[1:0];
      illegal = (size == 2'd3) || (uns && size == 2'd2) || (wr_en && uns);
      misal   = (size == 2'd1 && addr[0]) || (size == 2'd2 && lane != 2'd0);
      err     = is_mem && (illegal || misal);
      e.err   = err;
      e.req   = is_mem && !err;
      e.we    = wr_en;
      e.addr  = addr & 32'hFFFF_FFFC;
      e.regw  = regw & !err;
      e.alu   = addr;
      e.rd    = rdn;
      if (size == 2'd0) begin
         e.be    = 4'(1 << lane);
         e.wdata = {24'd0, sdata[7:0]} * 32'h0101_0101;
      end else if (size == 2'd1) begin
         e.be    = 4'(3 << (addr[1] ? 2 : 0));
         e.wdata = {16'd0, sdata[15:0]} * 32'h0001_0001;
      end else begin
         e.be    = 4'hF;
         e.wdata = sdata;
      end
      if (!is_mem || err || wr_en) begin
         e.rdata = 32'd0;
      end else if (size == 2'd0) begin
         v = (rdata >> (8 * lane)) & 32'hFF;
         if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
         e.rdata = v;
      end else if (size == 2'd1) begin
         v = (rdata >> (addr[1] ? 16 : 0)) & 32'hFFFF;
         if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
         e.rdata = v;
      end else begin
         e.rdata = rdata;
      end
      e.stalls = !is_mem ? 0 : (err ? 1 : delay + 2);

      @(posedge clk); #1;
      cur_delay    = delay;
      cur_rdata    = rdata;
      valid_i      = 1'b1;
      mem_read_i   = rd_en;
      mem_write_i  = wr_en;
      mem_to_reg_i = rd_en;
      reg_write_i  = regw;
      funct3_i     = f3;
      alu_result_i = addr;
      store_data_i = sdata;
      rd_i         = rdn;
      sb.push_back(e);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (stall_o === 1'b1 && n < 64);
      if (n >= 64) begin
         total++; bad++;
         $display("FAIL stall_bound: got stall after %0d cycles expected release", n);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; valid_i = 1'b0; alu_result_i = '0; store_data_i = '0;
      rd_i = '0; funct3_i = '0; mem_read_i = 1'b0; mem_write_i = 1'b0;
      mem_to_reg_i = 1'b0; reg_write_i = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req", dmem_req, 1'b0);
      chk("rst_we", dmem_we, 1'b0);
      chk("rst_be", dmem_be, 4'b0000);
      chk("rst_err", access_err_o, 1'b0);
      chk("rst_stall", stall_o, 1'b0);
      chk("rst_rdata", read_data_o, 32'd0);
      @(posedge clk); #1;
      reset  = 1'b1;
      mon_en = 1'b1;

      // Directed cases
      issue(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1, 5'd5);   // LW
      issue(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 0, 1, 5'd6);   // LB
      issue(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 1, 1, 5'd6);   // LBU
      issue(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 0, 0, 5'd0);   // SH
      issue(1, 0, 3'b010, 32'h101, 32'h0, 32'h12345678, 0, 1, 5'd7);   // LW misaligned
      issue(1, 0, 3'b010, 32'h104, 32'h0, 32'hCAFEF00D, 5, 1, 5'd8);   // slow ready
      issue(1, 0, 3'b011, 32'h108, 32'h0, 32'h0, 0, 1, 5'd9);          // illegal funct3
      issue(0, 1, 3'b100, 32'h108, 32'h55, 32'h0, 0, 0, 5'd0);         // store 1xx illegal
      issue(0, 0, 3'b000, 32'h0000ABCD, 32'h0, 32'h0, 0, 1, 5'd10);    // ADD
      issue(1, 0, 3'b101, 32'h10E, 32'h0, 32'h8001_7FFF, 0, 1, 5'd11); // LHU upper

      // Reset during REQ abandons the access; non-memory op right after
      @(posedge clk); #1;
      mon_en = 1'b0;
      cur_delay = 1000;
      valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0;
      funct3_i = 3'b010; alu_result_i = 32'h300; reg_write_i = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("req_before_reset", dmem_req, 1'b1);
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1; valid_i = 1'b0; mem_read_i = 1'b0; mem_to_reg_i = 1'b0;
      @(negedge clk);
      chk("req_after_reset", dmem_req, 1'b0);
      chk("be_after_reset", dmem_be, 4'b0000);
      chk("stall_after_reset", stall_o, 1'b0);
      alu_result_i = 32'h0000_1234; rd_i = 5'd7; reg_write_i = 1'b1; valid_i = 1'b1;
      #1;
      chk("add_stall", stall_o, 1'b0);
      chk("add_alu", alu_result_o, 32'h0000_1234);
      chk("add_rd", rd_o, 5'd7);
      chk("add_rdata", read_data_o, 32'd0);
      chk("add_regw", reg_write_o, 1'b1);
      @(posedge clk); #1;
      valid_i = 1'b0;
      mon_en  = 1'b1;

      // Random ops
      for (int i = 0; i < 150; i++) begin
         int k;
         k = $urandom_range(0, 2);
         issue(k == 1, k == 2, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
               $urandom_range(0, 4), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      end

      @(posedge clk); #1;
      valid_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
